// File: rtl/relu_sched_pkg.sv
// relu_sched_pkg
// Shared definitions for the ReLU round-robin scheduler slice.
//   STAT_W      width of the optional per-lane statistics counters
//   stat_cnt_t  one statistics counter
//   id_width()  lane-ID width for n lanes (never narrower than 1 bit)
package relu_sched_pkg;

    localparam int STAT_W = 16;

    typedef logic [STAT_W-1:0] stat_cnt_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_activation.sv
// relu_activation
// One-deep registered ReLU stage with a valid/ready handshake on both sides.
// A new beat is taken whenever the output register is empty or being drained.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_data     in   WIDTH  signed operand
//   in_valid    in   1      operand valid
//   in_ready    out  1      stage can take an operand this cycle
//   out_data    out  WIDTH  max(0, operand)
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream takes the result
module relu_activation #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    assign in_ready = out_ready | ~out_valid;

    // A negative operand is recognised by its sign bit alone, so the most
    // negative value clips to zero like any other negative number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data[WIDTH-1] ? '0 : in_data;
            end
        end
    end

endmodule

// File: rtl/rr_grant.sv
// rr_grant
// Combinational round-robin picker. The search starts at lane ptr and wraps
// modulo NUM_REQ; the first eligible lane it meets wins.
// Ports:
//   eligible      in   NUM_REQ  lanes that may be granted
//   ptr           in   ID_W     lane with highest priority this cycle
//   grant_onehot  out  NUM_REQ  one-hot grant, zero when nothing is eligible
//   grant_idx     out  ID_W     encoded index of the granted lane
//   any_grant     out  1        some lane is granted
module rr_grant
    import relu_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    // The outer loop walks priority order; the inner loop compares against
    // constant lane numbers so every bit select uses a constant index.
    always_comb begin
        int lane;
        lane         = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            lane = int'(ptr) + k;
            if (lane >= NUM_REQ) begin
                lane = lane - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any_grant && (i == lane) && eligible[i]) begin
                    any_grant       = 1'b1;
                    grant_onehot[i] = 1'b1;
                    grant_idx       = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/relu_rr_scheduler.sv
// relu_rr_scheduler
// Shares one relu_activation stage among NUM_REQ accumulator lanes using
// round-robin arbitration; every result carries the ID of its source lane.
// Optional statistics build: define RELU_SCHED_STATS_EN.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_data      in   NUM_REQ*ACC_W  lane i data at [i*ACC_W +: ACC_W]
//   req_valid     in   NUM_REQ        lane i offers a result
//   req_ready     out  NUM_REQ        one-hot-or-zero accept strobe
//   lane_enable   in   NUM_REQ        disabled lanes are never granted
//   res_data      out  ACC_W          ReLU of the granted data
//   res_id        out  ID_W           source lane of res_data
//   res_valid     out  1              result valid
//   res_ready     in   1              downstream accepts the result
//   busy          out  1              result held or any lane eligible
//   stat_sel      in   ID_W           (RELU_SCHED_STATS_EN) lane to read
//   stat_beats    out  16             (RELU_SCHED_STATS_EN) accepted beats
//   stat_clipped  out  16             (RELU_SCHED_STATS_EN) negative beats
module relu_rr_scheduler
    import relu_sched_pkg::*;
#(
    parameter int  ACC_W   = 64,
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ*ACC_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       lane_enable,
    output logic [ACC_W-1:0]         res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy
`ifdef RELU_SCHED_STATS_EN
    ,
    input  logic [ID_W-1:0]          stat_sel,
    output logic [STAT_W-1:0]        stat_beats,
    output logic [STAT_W-1:0]        stat_clipped
`endif
);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic [ID_W-1:0]    ptr;
    logic               offer;
    logic               stage_ready;
    logic               accept;
    logic [ACC_W-1:0]   sel_data;

    assign eligible = req_valid & lane_enable;

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_grant (
        .eligible     (eligible),
        .ptr          (ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_grant    (any_grant)
    );

    // The stage reports ready during reset because its output is empty;
    // gating with rst_n keeps req_ready low while reset is held.
    assign offer     = any_grant & rst_n;
    assign accept    = offer & stage_ready;
    assign req_ready = accept ? grant_onehot : '0;
    assign busy      = res_valid | (|eligible);

    // One-hot AND-OR mux avoids a variable part-select on req_data.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                sel_data = sel_data | req_data[i*ACC_W +: ACC_W];
            end
        end
    end

    relu_activation #(
        .WIDTH (ACC_W)
    ) u_relu (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (sel_data),
        .in_valid  (offer),
        .in_ready  (stage_ready),
        .out_data  (res_data),
        .out_valid (res_valid),
        .out_ready (res_ready)
    );

    // The pointer moves to the lane after the winner so that lane gets the
    // lowest priority next time; it holds when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            res_id <= '0;
        end else if (accept) begin
            res_id <= grant_idx;
            ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef RELU_SCHED_STATS_EN
    stat_cnt_t beats_q   [NUM_REQ];
    stat_cnt_t clipped_q [NUM_REQ];

    // Saturating counters; only the granted lane's pair can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beats_q[i]   <= '0;
                clipped_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_onehot[i]) begin
                    if (beats_q[i] != '1) begin
                        beats_q[i] <= beats_q[i] + 1'b1;
                    end
                    if (sel_data[ACC_W-1] && (clipped_q[i] != '1)) begin
                        clipped_q[i] <= clipped_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Selecting a lane number that does not exist reads back zero.
    always_comb begin
        stat_beats   = '0;
        stat_clipped = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == ID_W'(i)) begin
                stat_beats   = beats_q[i];
                stat_clipped = clipped_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_relu_rr_scheduler.sv
// tb_relu_rr_scheduler
// Directed scenarios followed by a randomized phase, all checked against a
// transaction-level reference of the scheduler kept in this file.
module tb_relu_rr_scheduler;

    localparam int ACC_W   = 16;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ*ACC_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       lane_enable;
    logic [ACC_W-1:0]         res_data;
    logic [ID_W-1:0]          res_id;
    logic                     res_valid;
    logic                     res_ready;
    logic                     busy;
`ifdef RELU_SCHED_STATS_EN
    logic [ID_W-1:0]          stat_sel;
    logic [15:0]              stat_beats;
    logic [15:0]              stat_clipped;
`endif

    logic signed [ACC_W-1:0] lane_data [NUM_REQ];

    // reference state
    bit                 exp_valid;
    logic [ACC_W-1:0]   exp_data;
    int                 exp_id;
    int                 exp_ptr;
    int                 exp_beats [NUM_REQ];
    int                 exp_clip  [NUM_REQ];
    int                 compare_count;
    int                 fail_count;

    relu_rr_scheduler #(
        .ACC_W   (ACC_W),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .lane_enable  (lane_enable),
        .res_data     (res_data),
        .res_id       (res_id),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy)
`ifdef RELU_SCHED_STATS_EN
        ,
        .stat_sel     (stat_sel),
        .stat_beats   (stat_beats),
        .stat_clipped (stat_clipped)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*ACC_W +: ACC_W] = lane_data[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_REQ-1:0] enable,
                                 input logic rdy);
        req_valid   = valid;
        lane_enable = enable;
        res_ready   = rdy;
    endtask

    task automatic modelReset();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_id    = 0;
        exp_ptr   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_beats[i] = 0;
            exp_clip[i]  = 0;
        end
    endtask

    // First eligible lane in the circular order ptr, ptr+1, ...; -1 if none.
    function automatic int modelGrant(input logic [NUM_REQ-1:0] elig, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (elig[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // One clock of the reference: check the handshake before the edge,
    // advance the reference at the edge, then check the registered result.
    task automatic runCycle(output int acc_lane);
        logic [NUM_REQ-1:0] elig;
        int g;
        bit acc;
        #1;
        elig = req_valid & lane_enable;
        g    = modelGrant(elig, exp_ptr);
        acc  = (g >= 0) && (res_ready || !exp_valid);
        checkOutput("req_ready", req_ready, acc ? (64'd1 << g) : 64'd0);
        checkOutput("busy", busy, exp_valid || (elig != 0));
        @(posedge clk);
        acc_lane = -1;
        if (acc) begin
            acc_lane  = g;
            exp_valid = 1'b1;
            exp_data  = (lane_data[g] < 0) ? '0 : lane_data[g];
            exp_id    = g;
            exp_ptr   = (g + 1) % NUM_REQ;
            if (exp_beats[g] < 65535) exp_beats[g]++;
            if (lane_data[g] < 0 && exp_clip[g] < 65535) exp_clip[g]++;
        end else if (res_ready) begin
            exp_valid = 1'b0;
        end
        #1;
        checkOutput("res_valid", res_valid, exp_valid);
        if (exp_valid) begin
            checkOutput("res_data", res_data, exp_data);
            checkOutput("res_id", res_id, exp_id);
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a;
        int corner_in  [5] = '{0, -1, 1, 32767, -32768};
        int corner_out [5] = '{0, 0, 1, 32767, 0};
        bit pending [NUM_REQ];

        compare_count = 0;
        fail_count    = 0;
        for (int i = 0; i < NUM_REQ; i++) lane_data[i] = '0;
`ifdef RELU_SCHED_STATS_EN
        stat_sel = '0;
`endif
        // reset state, with requests pending during reset
        rst_n = 1'b0;
        modelReset();
        applyStimulus('1, '1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_id", res_id, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_busy", busy, 1);
        @(negedge clk);
        applyStimulus('0, '1, 1'b1);
        rst_n = 1'b1;

        $display("[TB] corner values on lane 0");
        for (int j = 0; j < 5; j++) begin
            lane_data[0] = ACC_W'(corner_in[j]);
            applyStimulus(4'b0001, '1, 1'b1);
            runCycle(a);
            checkOutput("corner_data", res_data, 64'(corner_out[j]));
        end
        applyStimulus('0, '1, 1'b1);
        runCycle(a);
`ifdef RELU_SCHED_STATS_EN
        stat_sel = 2'd0;
        #1;
        checkOutput("stat_beats0", stat_beats, 5);
        checkOutput("stat_clipped0", stat_clipped, 2);
`endif

        $display("[TB] all lanes valid, rotating grants");
        resetDut();
        for (int i = 0; i < NUM_REQ; i++) lane_data[i] = ACC_W'(-5 + i);
        for (int k = 0; k < 8; k++) begin
            applyStimulus('1, '1, 1'b1);
            runCycle(a);
            checkOutput("rotate_id", res_id, k % NUM_REQ);
            checkOutput("rotate_data", res_data, 0);
        end

        $display("[TB] single lane back-to-back");
        lane_data[2] = 16'sd100;
        applyStimulus(4'b0100, '1, 1'b1);
        runCycle(a);
        checkOutput("single_data_a", res_data, 100);
        checkOutput("single_id_a", res_id, 2);
        lane_data[2] = 16'sd200;
        runCycle(a);
        checkOutput("single_data_b", res_data, 200);
        checkOutput("single_id_b", res_id, 2);

        $display("[TB] lane 2 disabled");
        for (int i = 0; i < NUM_REQ; i++) lane_data[i] = ACC_W'(10 * (i + 1));
        for (int k = 0; k < 6; k++) begin
            applyStimulus('1, 4'b1011, 1'b1);
            runCycle(a);
            checkOutput("lane2_ready", req_ready[2], 0);
        end

        $display("[TB] output backpressure");
        lane_data[1] = 16'sd7;
        applyStimulus(4'b0010, '1, 1'b1);
        runCycle(a);
        for (int k = 0; k < 3; k++) begin
            applyStimulus('1, '1, 1'b0);
            runCycle(a);
            checkOutput("stall_data", res_data, 7);
            checkOutput("stall_id", res_id, 1);
            checkOutput("stall_ready", req_ready, 0);
        end
        applyStimulus('1, '1, 1'b1);
        #1;
        checkOutput("release_ready", req_ready, 4'b0100);
        runCycle(a);
        checkOutput("release_id", res_id, 2);

        $display("[TB] asynchronous reset mid-stream");
        runCycle(a);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_res_valid", res_valid, 0);
        checkOutput("arst_req_ready", req_ready, 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("arst_restart", req_ready, 4'b0001);
        runCycle(a);
        checkOutput("arst_first_id", res_id, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < NUM_REQ; i++) pending[i] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            logic [NUM_REQ-1:0] v;
            v = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
                    pending[i] = 1'b1;
                    case ($urandom_range(0, 7))
                        0:       lane_data[i] = 16'sh8000;
                        1:       lane_data[i] = 16'sh7FFF;
                        default: lane_data[i] = ACC_W'($urandom);
                    endcase
                end
                v[i] = pending[i];
            end
            applyStimulus(v, NUM_REQ'($urandom_range(0, 15) | $urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0));
            runCycle(a);
            if (a >= 0) pending[a] = 1'b0;
        end
        applyStimulus('0, '1, 1'b1);
        runCycle(a);
`ifdef RELU_SCHED_STATS_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_sel = ID_W'(i);
            #1;
            checkOutput("stat_beats", stat_beats, 64'(exp_beats[i]));
            checkOutput("stat_clipped", stat_clipped, 64'(exp_clip[i]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/relu_rr_scheduler.md
Name: relu_rr_scheduler

Overview:
Shares one relu_activation stage among NUM_REQ accumulator lanes using round-robin arbitration.
- Each lane presents signed accumulator results on a valid/ready interface.
- The scheduler grants at most one lane per cycle and feeds the granted value through the ReLU stage.
- Each result is returned tagged with its source lane ID.
- Sits between the per-neuron bit-serial accumulators and the layer write-back/output buffer.

Parameters:
- ACC_W, 64, accumulator/result width (signed two's complement)
- NUM_REQ, 4, number of requesting lanes (>=1)
- ID_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), lane ID width; derived, not overridden

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_data  in  NUM_REQ*ACC_W  lane i data at bits [i*ACC_W +: ACC_W], signed
- req_valid  in  NUM_REQ  lane i has a result
- req_ready  out  NUM_REQ  one-hot-or-zero; lane i's beat accepted this cycle
- lane_enable  in  NUM_REQ  config mask; disabled lanes are never granted
- res_data  out  ACC_W  ReLU(granted data), signed
- res_id  out  ID_W  source lane of res_data
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- busy  out  1  res_valid OR any (req_valid & lane_enable)

Behaviour:
Clocking and reset:
- One clock: clk.
- Reset is asynchronous and active-low (rst_n).
- Reset values: res_valid=0, res_data=0, res_id=0, RR pointer=0.
- req_ready=0 while rst_n low.

Arbitration:
- eligible = req_valid & lane_enable.
- grant = first eligible lane searching ptr, ptr+1, ... with modulo NUM_REQ wrap. Purely combinational.
- can_accept = res_ready | ~res_valid. This is the same acceptance rule as relu_activation.
- accept = (eligible != 0) & can_accept.
- req_ready[grant] = accept; all other bits 0. req_ready may depend on req_valid; no lane may make req_valid depend on req_ready.

On accept (posedge):
- The ReLU stage captures req_data[grant].
- res_id <= grant.
- ptr <= (grant+1) mod NUM_REQ.
- No accept: ptr holds.

ReLU and latency:
- Latency is 1 cycle from accept to res_valid.
- ReLU: res_data = (x < 0) ? 0 : x. The most negative value gives 0; the most positive value passes unchanged.

Throughput and backpressure:
- One result per cycle when res_ready=1.
- With res_ready=1 and res_valid=1, a new accept and the output handoff occur in the same cycle.
- While res_valid=1 and res_ready=0: res_data and res_id hold stable and req_ready is all 0.

Boundary conditions:
- A single eligible lane is granted every cycle (no fairness bubble).
- All lanes disabled, or no valid: no grant, res_valid drains normally.
- A lane_enable change takes effect combinationally. It cannot revoke a beat already accepted (data is captured at that edge).
- A request from a lane with lane_enable=0 stays pending and is not dropped.
- Asynchronous reset mid-transfer discards the in-flight result. Lanes must re-present their data.
- NUM_REQ=1: res_id is always 0.

Optional Feature:
Macro: RELU_SCHED_STATS_EN

Defined:
- Adds ports stat_sel (in, ID_W), stat_beats (out, 16) and stat_clipped (out, 16).
- Per-lane 16-bit saturating counters:
  - beats: incremented on each accept of that lane.
  - clipped: incremented when the accepted data is negative.
- Counters saturate at 16'hFFFF and clear only on reset.
- stat_beats and stat_clipped are combinational reads of the lane selected by stat_sel.

Undefined:
- Ports and counters are absent.
- Core behaviour is identical.

Decomposition:
- Package relu_sched_pkg:
  - STAT_W=16 constant.
  - id_width(n) function returning max(1,$clog2(n)).
  - stat_cnt_t typedef (logic [STAT_W-1:0]).
- Sub-module rr_grant (parameter NUM_REQ): takes eligible and ptr, outputs a one-hot grant, the encoded index, and any_grant. Combinational, reusable by other schedulers.
- The ReLU datapath is the existing relu_activation, instantiated with out_ready=res_ready.
- The res_id register lives in the scheduler and is loaded on accept.

Test Plan:
1. NUM_REQ=4, all lanes valid continuously, res_ready=1, data lane i = -5+i → grants 0,1,2,3,0,…; res_data 0,0,0,0(lane3=-2)… then lane-order pattern repeats; res_id cycles 0..3; one result per cycle.
2. Only lane 2 valid with 100, then 200, back-to-back → both granted on consecutive cycles; res_id=2; res_data 100, 200.
3. lane_enable=4'b1011, all lanes valid → lane 2 never granted; req_ready[2]=0 throughout; lanes 0,1,3 rotate.
4. res_ready held 0 for 3 cycles with res_valid=1 (data 7, id 1) → res_data=7, res_id=1 stable; req_ready=0; on release the next lane is granted the same cycle.
5. Corner values 0, -1, 1, 32767, -32768 (ACC_W=16) on lane 0 → outputs 0, 0, 1, 32767, 0. With RELU_SCHED_STATS_EN: stat_beats[0]=5, stat_clipped[0]=2.
6. Assert rst_n=0 mid-stream with res_valid=1 → res_valid drops immediately; after release the RR pointer restarts at lane 0.
